// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX PHY; UART_TX_ARB_STATS_EN enables per-requester byte counters
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  tx_start,
    output logic [7:0]            byte_to_send,
    input  logic                  end_of_byte,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [16*NUM_REQ-1:0] byte_cnt
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, pick_idx, next_idx;
    logic                pick_found;
    logic [NUM_REQ-1:0]  grant_d, req_ready_d;
    logic [7:0]          byte_d;
    logic                last_q, last_d, tx_start_d, timeout_err_d, busy_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                tcnt_expired;
    logic [7:0]          data_arr [NUM_REQ];

    // (base + offs) modulo NUM_REQ, valid for non-power-of-two requester counts
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_arr[i] = req_data[8*i +: 8];
    end

    assign next_idx     = wrap_add(gidx_q, 1);
    assign tcnt_expired = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
    assign busy_d       = (state_d != IDLE);

    // Round-robin pick: first valid requester at or after rr_ptr
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d       = state_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant;
        byte_d        = byte_to_send;
        last_d        = last_q;
        tcnt_d        = tcnt_q;
        tx_start_d    = 1'b0;
        req_ready_d   = '0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gidx_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    tcnt_d            = '0;
                    state_d           = SEND;
                end
            end
            SEND: begin
                // A byte that is ready wins over a coincident expiry so it is never dropped
                if (req_valid[gidx_q]) begin
                    byte_d              = data_arr[gidx_q];
                    last_d              = req_last[gidx_q];
                    tx_start_d          = 1'b1;
                    req_ready_d[gidx_q] = 1'b1;
                    tcnt_d              = '0;
                    state_d             = WAIT_DONE;
                end else if (tcnt_expired) begin
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = next_idx;
                    tcnt_d        = '0;
                    state_d       = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            WAIT_DONE: begin
                // Completion in the expiry cycle counts as a normal completion
                if (end_of_byte) begin
                    tcnt_d = '0;
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_idx;
                        state_d  = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end else if (tcnt_expired) begin
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = next_idx;
                    tcnt_d        = '0;
                    state_d       = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gidx_q       <= '0;
            rr_ptr_q     <= '0;
            grant        <= '0;
            byte_to_send <= 8'h00;
            last_q       <= 1'b0;
            tcnt_q       <= '0;
            tx_start     <= 1'b0;
            req_ready    <= '0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            gidx_q       <= gidx_d;
            rr_ptr_q     <= rr_ptr_d;
            grant        <= grant_d;
            byte_to_send <= byte_d;
            last_q       <= last_d;
            tcnt_q       <= tcnt_d;
            tx_start     <= tx_start_d;
            req_ready    <= req_ready_d;
            timeout_err  <= timeout_err_d;
            busy         <= busy_d;
        end
    end

`ifdef UART_TX_ARB_STATS_EN
    logic        cnt_inc;
    logic [15:0] cnt_q [NUM_REQ];

    assign cnt_inc = (state_q == WAIT_DONE) && end_of_byte;

    // Saturating completed-byte counter for the granted requester
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset)
                cnt_q[i] <= '0;
            else if (cnt_inc && (gidx_q == IDX_W'(i)) && (cnt_q[i] != 16'hFFFF))
                cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        assign byte_cnt[16*i +: 16] = cnt_q[i];
    end
`else
    assign byte_cnt = '0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing the UART TX PHY (legal 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, 100_000, cycles allowed per byte (SEND wait or WAIT_DONE) before abort (legal >= 2).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte available.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte, slice i = [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  byte on req_data slice i is the last of its message.
REQ-008 req_ready  output  NUM_REQ  one-cycle pulse: requester's byte accepted.
REQ-009 grant  output  NUM_REQ  one-hot owner of the PHY; all zero when idle.
REQ-010 tx_start  output  1  one-cycle start pulse to the TX PHY.
REQ-011 byte_to_send  output  8  byte presented to the TX PHY, stable from tx_start until end_of_byte.
REQ-012 end_of_byte  input  1  TX PHY completion pulse.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on abort.
REQ-015 byte_cnt  output  16*NUM_REQ  per-requester completed-byte counters (see Configuration).

Function
REQ-016 States SHALL be IDLE, SEND, WAIT_DONE; all outputs registered.
REQ-017 IDLE: if any req_valid, grant SHALL go to the first requesting index at or after rr_ptr (wrapping NUM_REQ-1 -> 0); next state SEND.
REQ-018 Grant SHALL be held for a whole message, from its first byte through completion of the byte flagged req_last.
REQ-019 SEND: when req_valid[g] is high, byte_to_send <= req_data slice g, last_q <= req_last[g], tx_start and req_ready[g] SHALL pulse high together for exactly one cycle; next state WAIT_DONE.
REQ-020 Latency: req_valid first seen in IDLE at cycle n -> tx_start and req_ready high at cycle n+2.
REQ-021 WAIT_DONE: on end_of_byte, byte_cnt[g] increments; if last_q then rr_ptr <= g+1 (mod NUM_REQ), grant cleared, go IDLE; else go SEND.
REQ-022 Back-to-back bytes of one message: tx_start for byte k+1 SHALL occur 2 cycles after end_of_byte of byte k when req_valid is already high.
REQ-023 end_of_byte received in IDLE or SEND SHALL be ignored.
REQ-024 Timeout counter SHALL clear on entry to SEND and WAIT_DONE and count every cycle in those states; on reaching TIMEOUT_CYCLES: timeout_err pulses, grant cleared, rr_ptr <= g+1, go IDLE, no req_ready.
REQ-025 end_of_byte in the same cycle as timeout expiry SHALL win (normal completion, no timeout_err).
REQ-026 req_valid of non-granted requesters SHALL be ignored while a grant is held; req_ready SHALL never pulse for a non-granted index.

Reset
REQ-027 reset SHALL force state IDLE, rr_ptr 0, grant 0, req_ready 0, tx_start 0, byte_to_send 8'h00, busy 0, timeout_err 0, byte_cnt 0, timeout counter 0.
REQ-028 reset mid-message SHALL abort it in the next cycle with no further tx_start or req_ready.

Configuration
REQ-029 Macro UART_TX_ARB_STATS_EN SHALL gate the byte_cnt counters.
REQ-030 With UART_TX_ARB_STATS_EN defined: each 16-bit counter increments per completed byte and saturates at 16'hFFFF.
REQ-031 Without it: byte_cnt SHALL be tied to zero and no counter registers synthesised; the port list is unchanged.

Verification
REQ-032 Req0 single 1-byte message 8'h41, last=1, end_of_byte 20 cycles after tx_start -> tx_start at n+2, byte_to_send 8'h41, grant 4'b0001, IDLE after done, byte_cnt[0]=1.
REQ-033 Req1 and req2 both valid from reset, 2-byte messages each -> order R1,R1,R2,R2; grant never switches mid-message; rr_ptr=3 at end.
REQ-034 All four requesters permanently valid with 1-byte messages, 8 bytes -> grant order 0,1,2,3,0,1,2,3.
REQ-035 TIMEOUT_CYCLES=16, end_of_byte withheld -> timeout_err pulse 16 cycles after WAIT_DONE entry, grant 0, byte_cnt unchanged, next requester served.
REQ-036 end_of_byte coincident with timeout expiry -> no timeout_err, byte_cnt increments; end_of_byte in IDLE -> no state change.
REQ-037 reset asserted one cycle after tx_start of a 3-byte message -> all outputs at reset values next cycle; with macro undefined byte_cnt reads 0 throughout.
